// File: rtl/spiflash_reader_pkg.sv
// Opcodes, FSM state encoding and byte-order helper shared by the SPI flash read path.
package spiflash_reader_pkg;

    localparam logic [7:0] OP_WAKE    = 8'hAB;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_QREAD   = 8'hEB;
    localparam logic [7:0] MODE_NOXIP = 8'h00;

    typedef enum logic [2:0] {
        ST_WAKE,
        ST_GAP,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA
    } state_t;

    // The shift register collects bytes in wire order; the bus wants byte 0 in the low lane.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spiflash_reader_if.sv
// Word read request/response channel between the SoC bus arbiter and the flash reader.
interface spiflash_reader_if;

    logic        quad_en;
    logic        rd_valid;
    logic [23:0] rd_addr;
    logic        rd_ready;
    logic [31:0] rd_rdata;
    logic        busy;

    modport master (output quad_en, rd_valid, rd_addr, input rd_ready, rd_rdata, busy);
    modport slave  (input quad_en, rd_valid, rd_addr, output rd_ready, rd_rdata, busy);

endinterface

// File: rtl/spiflash_reader_bittimer.sv
// SPI mode-0 bit clock: CLK_DIV cycles low then CLK_DIV high per bit, plus a sample strobe on the last high cycle.
// Free-runs while en is high; dropping en returns the clock low and restarts the bit phase.
module spiflash_reader_bittimer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic sclk,
    output logic sample_stb
);

    localparam int                CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  RISE  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign sample_stb = en && (cnt == LAST);

    // sclk is registered, so it is computed from the phase it will be in next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            sclk <= (cnt >= RISE) && (cnt != LAST);
        end
    end

endmodule

// File: rtl/spiflash_reader.sv
// SPI flash word reader: wakes the flash once after reset, then serves 0x03 / 0xEB word reads.
// Latency 64 (single) or 24+DUMMY_CYCLES (quad) SPI clocks; requests wait in rd_valid until IDLE.
module spiflash_reader
    import spiflash_reader_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 8,
    parameter int CSB_GAP      = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    spiflash_reader_if.slave         bus,
    output logic                     flash_csb,
    output logic                     flash_clk,
    output logic [3:0]               flash_io_oe,
    output logic [3:0]               flash_io_do,
    input  logic [3:0]               flash_io_di
);

    localparam int GAP_W = $clog2(CSB_GAP + 1);

    state_t             state;
    logic [5:0]         bit_cnt;
    logic [5:0]         phase_last;
    logic [GAP_W-1:0]   gap_cnt;
    logic [31:0]        sr;
    logic [31:0]        sr_shift;
    logic [23:0]        addr_q;
    logic               quad_q;
    logic               wide;
    logic               bit_stb;
    logic               last_bit;

    spiflash_reader_bittimer #(.CLK_DIV(CLK_DIV)) u_bittimer (
        .clk        (clk),
        .resetn     (resetn),
        .en         (~flash_csb),
        .sclk       (flash_clk),
        .sample_stb (bit_stb)
    );

    // Opcode is always single-bit; everything after it is nibble-wide in quad mode.
    assign wide     = quad_q && (state inside {ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA});
    assign sr_shift = wide ? {sr[27:0], flash_io_di} : {sr[30:0], flash_io_di[1]};
    assign last_bit = bit_stb && (bit_cnt == phase_last);
    assign flash_io_do = flash_io_oe & (wide ? sr[31:28] : {3'b000, sr[31]});

    always_comb begin
        phase_last = 6'd7;
        case (state)
            ST_ADDR:  phase_last = quad_q ? 6'd5 : 6'd23;
            ST_MODE:  phase_last = 6'd1;
            ST_DUMMY: phase_last = 6'(DUMMY_CYCLES - 1);
            ST_DATA:  phase_last = quad_q ? 6'd7 : 6'd31;
            default:  phase_last = 6'd7;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_WAKE;
            flash_csb    <= 1'b1;
            flash_io_oe  <= 4'b0000;
            sr           <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            addr_q       <= '0;
            quad_q       <= 1'b0;
            bus.rd_ready <= 1'b0;
            bus.rd_rdata <= '0;
            bus.busy     <= 1'b1;
        end else begin
            bus.rd_ready <= 1'b0;
            if (bit_stb) begin
                bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
                sr      <= last_bit ? 32'h0 : sr_shift;
            end
            case (state)
                ST_WAKE: begin
                    if (flash_csb) begin
                        flash_csb   <= 1'b0;
                        flash_io_oe <= 4'b0001;
                        sr          <= {OP_WAKE, 24'h0};
                    end else if (last_bit) begin
                        state       <= ST_GAP;
                        flash_csb   <= 1'b1;
                        flash_io_oe <= 4'b0000;
                        gap_cnt     <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(CSB_GAP - 1)) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (bus.rd_valid) begin
                        state       <= ST_CMD;
                        flash_csb   <= 1'b0;
                        flash_io_oe <= 4'b0001;
                        bus.busy    <= 1'b1;
                        addr_q      <= bus.rd_addr & 24'hFF_FFFC;
                        quad_q      <= bus.quad_en;
                        sr          <= {(bus.quad_en ? OP_QREAD : OP_READ), 24'h0};
                    end
                end
                ST_CMD: begin
                    if (last_bit) begin
                        state       <= ST_ADDR;
                        sr          <= {addr_q, 8'h00};
                        flash_io_oe <= quad_q ? 4'b1111 : 4'b0001;
                    end
                end
                ST_ADDR: begin
                    if (last_bit) begin
                        state       <= quad_q ? ST_MODE : ST_DATA;
                        sr          <= quad_q ? {MODE_NOXIP, 24'h0} : 32'h0;
                        flash_io_oe <= quad_q ? 4'b1111 : 4'b0001;
                    end
                end
                ST_MODE: begin
                    if (last_bit) begin
                        state       <= ST_DUMMY;
                        flash_io_oe <= 4'b0000;
                    end
                end
                ST_DUMMY: begin
                    if (last_bit) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (last_bit) begin
                        state        <= ST_GAP;
                        flash_csb    <= 1'b1;
                        flash_io_oe  <= 4'b0000;
                        gap_cnt      <= '0;
                        bus.rd_ready <= 1'b1;
                        bus.rd_rdata <= bswap32(sr_shift);
                    end
                end
                default: state <= ST_WAKE;
            endcase
        end
    end

endmodule

// File: tb/tb_spiflash_reader.sv
// Directed bench for spiflash_reader with a behavioural SPI flash model driving the io pins.
module tb_spiflash_reader;

    localparam int CLK_DIV      = 2;
    localparam int DUMMY_CYCLES = 8;
    localparam int CSB_GAP      = 4;

    logic       clk    = 1'b0;
    logic       resetn = 1'b1;
    logic       flash_csb;
    logic       flash_clk;
    logic [3:0] flash_io_oe;
    logic [3:0] flash_io_do;
    logic [3:0] flash_io_di;

    spiflash_reader_if bus ();

    spiflash_reader #(
        .CLK_DIV      (CLK_DIV),
        .DUMMY_CYCLES (DUMMY_CYCLES),
        .CSB_GAP      (CSB_GAP)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .flash_csb   (flash_csb),
        .flash_clk   (flash_clk),
        .flash_io_oe (flash_io_oe),
        .flash_io_do (flash_io_do),
        .flash_io_di (flash_io_di)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- flash model ----------------
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    bit          in_frame     = 1'b0;
    int          fl_clks      = 0;
    int          fl_frames    = 0;
    int          fl_wakes     = 0;
    int          fl_last_clks = 0;
    int          fl_oe_bad    = 0;
    logic [7:0]  fl_op        = 8'h00;
    logic [7:0]  fl_mode      = 8'hFF;
    logic [23:0] fl_addr      = 24'h0;
    logic [3:0]  fl_di        = 4'h0;
    logic [3:0]  exp_oe;
    logic [7:0]  fl_b;
    int          fl_idx;

    assign flash_io_di = fl_di;

    always @(negedge flash_csb or posedge flash_csb or posedge flash_clk) begin
        if (flash_csb === 1'b1) begin
            if (in_frame) begin
                fl_last_clks = fl_clks;
                in_frame     = 1'b0;
            end
        end else if (!in_frame) begin
            in_frame = 1'b1;
            fl_frames++;
            fl_clks = 0;
            fl_op   = 8'h00;
            fl_addr = 24'h0;
            fl_mode = 8'hFF;
        end else begin
            exp_oe = (fl_clks < 8 || fl_op == 8'h03) ? 4'b0001 :
                     (fl_clks < 16) ? 4'b1111 : 4'b0000;
            if (flash_io_oe !== exp_oe) fl_oe_bad++;
            if (fl_op == 8'h03 && fl_clks >= 32 && flash_io_do[0] !== 1'b0) fl_oe_bad++;
            if (fl_clks < 8)                         fl_op   = {fl_op[6:0], flash_io_do[0]};
            else if (fl_op == 8'h03 && fl_clks < 32) fl_addr = {fl_addr[22:0], flash_io_do[0]};
            else if (fl_op == 8'hEB && fl_clks < 14) fl_addr = {fl_addr[19:0], flash_io_do};
            else if (fl_op == 8'hEB && fl_clks < 16) fl_mode = {fl_mode[3:0], flash_io_do};
            fl_clks++;
            if (fl_clks == 8 && fl_op == 8'hAB) fl_wakes++;
        end
    end

    // Flash shifts read data out on the falling edge, as a mode-0 slave does.
    always @(negedge flash_clk or posedge flash_csb) begin
        if (flash_csb === 1'b1) begin
            fl_di = 4'h0;
        end else if (fl_op == 8'h03 && fl_clks >= 32) begin
            fl_idx = fl_clks - 32;
            fl_b   = mem_byte(fl_addr + 24'(fl_idx / 8));
            fl_di  = {2'b00, fl_b[7 - (fl_idx % 8)], 1'b0};
        end else if (fl_op == 8'hEB && fl_clks >= 24) begin
            fl_idx = fl_clks - 24;
            fl_b   = mem_byte(fl_addr + 24'(fl_idx / 2));
            fl_di  = (fl_idx % 2 == 0) ? fl_b[7:4] : fl_b[3:0];
        end
    end

    // ---------------- bus-side monitor ----------------
    int csb_low_cyc  = 0;
    int ready_cnt    = 0;
    int ready_double = 0;
    bit prev_rdy     = 1'b0;

    always @(negedge clk) begin
        if (flash_csb === 1'b0) csb_low_cyc++;
        if (bus.rd_ready === 1'b1) begin
            ready_cnt++;
            if (prev_rdy) ready_double++;
        end
        prev_rdy = (bus.rd_ready === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_req(input logic [23:0] a, input logic q);
        bus.rd_addr  = a;
        bus.quad_en  = q;
        bus.rd_valid = 1'b1;
    endtask

    task automatic wait_ready(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.rd_ready === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic ok;
        bit   seen_low;
        int   gap;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = 24'h0;
        bus.quad_en  = 1'b0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (flash_csb !== 1'b1) begin n_fail++; $display("FAIL reset_csb: got %b want 1", flash_csb); end
        n_checks++; if (flash_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", flash_clk); end
        n_checks++; if (flash_io_oe !== 4'b0000) begin n_fail++; $display("FAIL reset_oe: got %b want 0000", flash_io_oe); end
        n_checks++; if (flash_io_do !== 4'b0000) begin n_fail++; $display("FAIL reset_do: got %b want 0000", flash_io_do); end
        n_checks++; if (bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.rd_ready); end
        n_checks++; if (bus.rd_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rd_rdata); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
        resetn   = 1'b1;
        seen_low = 1'b0;
        gap      = 0;
        ok       = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (flash_csb === 1'b0) seen_low = 1'b1;
            else if (seen_low && bus.busy === 1'b1) gap++;
            if (seen_low && bus.busy === 1'b0) ok = 1'b1;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wake_idle: busy still %b after 500 cycles, want 0", bus.busy); end
        n_checks++; if (fl_frames != 1) begin n_fail++; $display("FAIL wake_frames: got %0d want 1", fl_frames); end
        n_checks++; if (fl_wakes != 1 || fl_op !== 8'hAB) begin n_fail++; $display("FAIL wake_opcode: got %h (%0d wakes) want AB (1)", fl_op, fl_wakes); end
        n_checks++; if (fl_last_clks != 8) begin n_fail++; $display("FAIL wake_clks: got %0d want 8", fl_last_clks); end
        n_checks++; if (gap < 1 || gap > CSB_GAP) begin n_fail++; $display("FAIL wake_busy_drop: got %0d cycles want 1..%0d", gap, CSB_GAP); end
    endtask

    task automatic test_single_read();
        logic        ok;
        logic [31:0] data;
        int          low, f0, r0;
        f0 = fl_frames; r0 = ready_cnt; csb_low_cyc = 0;
        start_req(24'h000100, 1'b0);
        wait_ready(ok);
        data = bus.rd_rdata; low = csb_low_cyc;
        bus.rd_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: no rd_ready, want one"); end
        n_checks++; if (fl_op !== 8'h03) begin n_fail++; $display("FAIL single_opcode: got %h want 03", fl_op); end
        n_checks++; if (fl_addr !== 24'h000100) begin n_fail++; $display("FAIL single_addr: got %h want 000100", fl_addr); end
        n_checks++; if (data !== 32'h44332211) begin n_fail++; $display("FAIL single_data: got %h want 44332211", data); end
        n_checks++; if (fl_last_clks != 64) begin n_fail++; $display("FAIL single_sclks: got %0d want 64", fl_last_clks); end
        n_checks++; if (low != 256) begin n_fail++; $display("FAIL single_latency: csb low %0d cycles want 256", low); end
        n_checks++; if (ready_cnt - r0 != 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", ready_cnt - r0); end
        n_checks++; if (fl_frames - f0 != 1) begin n_fail++; $display("FAIL single_frames: got %0d want 1", fl_frames - f0); end
        n_checks++; if (bus.rd_rdata !== 32'h44332211) begin n_fail++; $display("FAIL single_hold: got %h want 44332211", bus.rd_rdata); end
        n_checks++; if (fl_oe_bad != 0) begin n_fail++; $display("FAIL single_oe: %0d bad pin samples want 0", fl_oe_bad); end
    endtask

    task automatic test_quad_read();
        logic        ok;
        logic [31:0] data;
        int          low;
        csb_low_cyc = 0;
        start_req(24'h000100, 1'b1);
        wait_ready(ok);
        data = bus.rd_rdata; low = csb_low_cyc;
        bus.rd_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL quad_timeout: no rd_ready, want one"); end
        n_checks++; if (fl_op !== 8'hEB) begin n_fail++; $display("FAIL quad_opcode: got %h want EB", fl_op); end
        n_checks++; if (fl_addr !== 24'h000100) begin n_fail++; $display("FAIL quad_addr: got %h want 000100", fl_addr); end
        n_checks++; if (fl_mode !== 8'h00) begin n_fail++; $display("FAIL quad_mode: got %h want 00", fl_mode); end
        n_checks++; if (data !== 32'h44332211) begin n_fail++; $display("FAIL quad_data: got %h want 44332211", data); end
        n_checks++; if (fl_last_clks != 32) begin n_fail++; $display("FAIL quad_sclks: got %0d want 32", fl_last_clks); end
        n_checks++; if (low != 128) begin n_fail++; $display("FAIL quad_latency: csb low %0d cycles want 128", low); end
        n_checks++; if (fl_oe_bad != 0) begin n_fail++; $display("FAIL quad_oe: %0d bad pin samples want 0", fl_oe_bad); end
    endtask

    task automatic test_drop_and_change();
        logic        ok, acc;
        logic [31:0] data;
        int          r0;
        r0  = ready_cnt;
        acc = 1'b0;
        start_req(24'h000100, 1'b0);
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (flash_csb === 1'b0) acc = 1'b1;
        end
        bus.rd_valid = 1'b0;
        bus.quad_en  = 1'b1;
        bus.rd_addr  = 24'h000000;
        wait_ready(ok);
        data = bus.rd_rdata;
        repeat (20) @(negedge clk);
        n_checks++; if (!(acc && ok)) begin n_fail++; $display("FAIL drop_complete: accepted %b ready %b want 1 1", acc, ok); end
        n_checks++; if (fl_op !== 8'h03 || fl_addr !== 24'h000100) begin n_fail++; $display("FAIL drop_latched: got %h/%h want 03/000100", fl_op, fl_addr); end
        n_checks++; if (data !== 32'h44332211) begin n_fail++; $display("FAIL drop_data: got %h want 44332211", data); end
        n_checks++; if (ready_cnt - r0 != 1) begin n_fail++; $display("FAIL drop_pulses: got %0d want 1", ready_cnt - r0); end
    endtask

    task automatic test_back_to_back();
        logic        ok1, ok2;
        logic [31:0] d1, d2;
        int          hi, f0, r0;
        f0 = fl_frames; r0 = ready_cnt;
        start_req(24'h000000, 1'b0);
        wait_ready(ok1);
        d1 = bus.rd_rdata;
        bus.rd_addr = 24'h000004;
        hi = (flash_csb === 1'b1) ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (flash_csb !== 1'b1) break;
            hi++;
        end
        wait_ready(ok2);
        d2 = bus.rd_rdata;
        bus.rd_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_timeout: ready %b %b want 1 1", ok1, ok2); end
        n_checks++; if (d1 !== 32'h59585B5A) begin n_fail++; $display("FAIL b2b_word0: got %h want 59585B5A", d1); end
        n_checks++; if (d2 !== 32'h5D5C5F5E) begin n_fail++; $display("FAIL b2b_word1: got %h want 5D5C5F5E", d2); end
        n_checks++; if (hi < CSB_GAP) begin n_fail++; $display("FAIL b2b_gap: csb high %0d cycles want >= %0d", hi, CSB_GAP); end
        n_checks++; if (fl_frames - f0 != 2) begin n_fail++; $display("FAIL b2b_frames: got %0d want 2", fl_frames - f0); end
        n_checks++; if (ready_cnt - r0 != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", ready_cnt - r0); end
        n_checks++; if (ready_double != 0) begin n_fail++; $display("FAIL ready_width: %0d multi-cycle pulses want 0", ready_double); end
    endtask

    task automatic test_reset_mid();
        logic        ok, hit;
        logic [31:0] data;
        int          w0;
        hit = 1'b0;
        start_req(24'h000100, 1'b1);
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            if (flash_csb === 1'b0 && fl_clks >= 26) hit = 1'b1;
        end
        resetn = 1'b0;
        bus.rd_valid = 1'b0;
        #1;
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach: data phase not reached, want reached"); end
        n_checks++; if (flash_csb !== 1'b1 || flash_io_oe !== 4'b0000) begin n_fail++; $display("FAIL rstmid_pins: csb %b oe %b want 1 0000", flash_csb, flash_io_oe); end
        n_checks++; if (flash_clk !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: sclk %b busy %b want 0 1", flash_clk, bus.busy); end
        n_checks++; if (bus.rd_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", bus.rd_rdata); end
        repeat (2) @(negedge clk);
        w0 = fl_wakes;
        resetn = 1'b1;
        wait_idle(ok);
        n_checks++; if (!ok || fl_wakes - w0 != 1) begin n_fail++; $display("FAIL rstmid_wake: idle %b wakes %0d want 1 1", ok, fl_wakes - w0); end
        start_req(24'h000100, 1'b1);
        wait_ready(ok);
        data = bus.rd_rdata;
        bus.rd_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (!ok || data !== 32'h44332211) begin n_fail++; $display("FAIL rstmid_read: got %h (ready %b) want 44332211", data, ok); end
    endtask

    task automatic test_unaligned_top();
        logic        ok;
        logic [31:0] data;
        start_req(24'hFFFFFE, 1'b1);
        wait_ready(ok);
        data = bus.rd_rdata;
        bus.rd_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL top_timeout: no rd_ready, want one"); end
        n_checks++; if (fl_addr !== 24'hFFFFFC) begin n_fail++; $display("FAIL top_addr: got %h want FFFFFC", fl_addr); end
        n_checks++; if (data !== 32'hA5A4A7A6) begin n_fail++; $display("FAIL top_data: got %h want A5A4A7A6", data); end
        n_checks++; if (fl_oe_bad != 0) begin n_fail++; $display("FAIL final_oe: %0d bad pin samples want 0", fl_oe_bad); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_quad_read();
        test_drop_and_change();
        test_back_to_back();
        test_reset_mid();
        test_unaligned_top();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
